custom_subtractor45_13_seq: RTL and testbench

- Inverse of the 44-bit + zero-extended-13-bit adder in the arithmetic datapath: takes a 45-bit sum and the 13-bit small operand, and recovers the 44-bit large operand.
- Computes Diff = Sum − {32'b0, B} serially, LSB chunk first, with a registered borrow chain.
- Valid/ready handshake on both input and output; one operation in flight.
- Flags results that are not a legal 44-bit operand: underflow, or bit 44 left set.

---
 rtl/custom_subtractor45_13_seq_if.sv | 26 ++
 rtl/custom_subtractor45_13_seq.sv | 103 ++++++++++
 tb/tb_custom_subtractor45_13_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/custom_subtractor45_13_seq_if.sv
// Handshake bundle for the serial 45-bit minus 13-bit subtractor.
// Master drives operands and accepts results; slave is the subtractor.
interface custom_subtractor45_13_seq_if #(
  parameter int SUM_WIDTH = 45,
  parameter int B_WIDTH   = 13
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SUM_WIDTH-1:0] Sum;
  logic [B_WIDTH-1:0]   B;
  logic                 out_valid;
  logic                 out_ready;
  logic [SUM_WIDTH-2:0] A;
  logic                 underflow;
  logic                 overflow;

  modport master (
    output in_valid, Sum, B, out_ready,
    input  in_ready, out_valid, A, underflow, overflow
  );

  modport slave (
    input  in_valid, Sum, B, out_ready,
    output in_ready, out_valid, A, underflow, overflow
  );
endinterface

// File: rtl/custom_subtractor45_13_seq.sv
// Serial Sum - zext(B) subtractor: one CHUNK_WIDTH slice per cycle, LSB first,
// with a registered borrow. Recovers the 44-bit operand and flags illegal results.
module custom_subtractor45_13_seq #(
  parameter int SUM_WIDTH   = 45,
  parameter int B_WIDTH     = 13,
  parameter int CHUNK_WIDTH = 15
) (
  input logic                        clk,
  input logic                        rst,
  custom_subtractor45_13_seq_if.slave bus
);
  localparam int NUM_CHUNKS = SUM_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_reg;
  logic [SUM_WIDTH-1:0] sum_reg;
  logic [SUM_WIDTH-1:0] sub_reg;
  logic [SUM_WIDTH-1:0] diff_reg;
  logic                 borrow_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic [SUM_WIDTH-2:0] a_reg;
  logic                 underflow_reg;
  logic                 overflow_reg;

  logic [CHUNK_WIDTH:0]   chunk_next;
  logic [SUM_WIDTH-1:0]   diff_next;

  // Operands shift right each cycle so the active slice is always the low chunk;
  // result chunks enter from the top so the difference ends up aligned.
  assign chunk_next = {1'b0, sum_reg[CHUNK_WIDTH-1:0]}
                    - {1'b0, sub_reg[CHUNK_WIDTH-1:0]}
                    - {{CHUNK_WIDTH{1'b0}}, borrow_reg};
  assign diff_next  = {chunk_next[CHUNK_WIDTH-1:0], diff_reg[SUM_WIDTH-1:CHUNK_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sum_reg       <= '0;
      sub_reg       <= '0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sum_reg      <= bus.Sum;
            sub_reg      <= {{(SUM_WIDTH-B_WIDTH){1'b0}}, bus.B};
            borrow_reg   <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          sum_reg    <= sum_reg >> CHUNK_WIDTH;
          sub_reg    <= sub_reg >> CHUNK_WIDTH;
          diff_reg   <= diff_next;
          borrow_reg <= chunk_next[CHUNK_WIDTH];
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CHUNK) begin
            // Final borrow out of the top chunk means Sum < B.
            a_reg         <= diff_next[SUM_WIDTH-2:0];
            underflow_reg <= chunk_next[CHUNK_WIDTH];
            overflow_reg  <= ~chunk_next[CHUNK_WIDTH] & diff_next[SUM_WIDTH-1];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.A         = a_reg;
  assign bus.underflow = underflow_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_custom_subtractor45_13_seq.sv
// Scoreboard bench: driver pushes model results on accept, monitor pops on
// the output handshake and also checks outputs stay frozen under backpressure.
module tb_custom_subtractor45_13_seq;
  typedef struct {
    logic [43:0] a;
    logic        uf;
    logic        of;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  custom_subtractor45_13_seq_if bus ();

  custom_subtractor45_13_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain integer subtraction on a wider word.
  function automatic exp_t model(input logic [44:0] s, input logic [12:0] b);
    exp_t        e;
    logic [45:0] t;
    t    = {1'b0, s} - {33'b0, b};
    e.a  = t[43:0];
    e.uf = (s < {32'b0, b});
    e.of = !e.uf && t[44];
    return e;
  endfunction

  // Monitor
  logic        prev_valid = 1'b0;
  logic [43:0] prev_a;
  logic        prev_uf, prev_of;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && prev_valid) begin
        check("hold_A", 64'(bus.A), 64'(prev_a));
        check("hold_flags", {62'b0, bus.underflow, bus.overflow}, {62'b0, prev_uf, prev_of});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got A=%h with empty scoreboard, expected none", bus.A);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("result A=%h uf=%0b of=%0b (exp A=%h uf=%0b of=%0b)",
                   bus.A, bus.underflow, bus.overflow, e.a, e.uf, e.of);
          check("A", 64'(bus.A), 64'(e.a));
          check("underflow", 64'(bus.underflow), 64'(e.uf));
          check("overflow", 64'(bus.overflow), 64'(e.of));
        end
      end
      prev_valid = bus.out_valid;
      prev_a     = bus.A;
      prev_uf    = bus.underflow;
      prev_of    = bus.overflow;
    end
  end

  // Issue one operation; accept it, check latency, apply hold cycles of backpressure.
  task automatic do_op(input logic [44:0] s, input logic [12:0] b, input int hold);
    int          n;
    logic [63:0] junk;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.Sum      = s;
    bus.B        = b;
    @(posedge clk);
    exp_q.push_back(model(s, b));
    #1;
    bus.in_valid = 1'b0;
    check("in_ready_busy", 64'(bus.in_ready), 64'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 20);
    check("latency", 64'(n), 64'd3);
    for (int i = 0; i < hold; i++) begin
      junk         = {$urandom(), $urandom()};
      bus.in_valid = 1'b1;
      bus.Sum      = junk[44:0];
      bus.B        = junk[63:51];
      check("in_ready_bp", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", 64'(bus.out_valid), 64'd0);
    check("in_ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    logic [44:0] s;
    logic [12:0] b;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Sum       = '0;
    bus.B         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_A", 64'(bus.A), 64'd0);
    check("rst_flags", {62'b0, bus.underflow, bus.overflow}, 64'd0);
    rst = 1'b0;

    do_op(45'h0000_0000_1234, 13'h0234, 0);
    do_op(45'h0000_0010_0000, 13'h0001, 0);
    do_op(45'd5, 13'd6, 0);
    do_op(45'h1000_0000_0000, 13'h0000, 0);
    do_op(45'h0ABC_DEF0_3233, 13'h1FFF, 10);

    // Reset on the second CALC edge discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.Sum      = 45'h1555_5555_5555;
    bus.B        = 13'h0AAA;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_flags", {62'b0, bus.underflow, bus.overflow}, 64'd0);
    check("midrst_A", 64'(bus.A), 64'd0);
    do_op(45'h10, 13'h1, 0);

    for (int i = 0; i < 40; i++) begin
      r = {$urandom(), $urandom()};
      s = r[44:0];
      b = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 3) == 0) s = 45'($urandom_range(0, 8191));
      do_op(s, b, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
